// File: rtl/pcie_rx_tlp_parser_if.sv
// Bundle of the core RX stream, decoded-header handshake and realigned payload stream.
// The parser uses the slave modport; the environment feeding it uses master.
interface pcie_rx_tlp_parser_if;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tlast;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [21:0] rx_tuser;

  logic        hdr_valid;
  logic        hdr_ready;
  logic [1:0]  hdr_fmt;
  logic [4:0]  hdr_type;
  logic [10:0] hdr_len;
  logic [15:0] hdr_reqid;
  logic [7:0]  hdr_tag;
  logic [3:0]  hdr_firstbe;
  logic [3:0]  hdr_lastbe;
  logic [61:0] hdr_addr;
  logic [7:0]  hdr_bar;
  logic [15:0] hdr_cplid;
  logic [2:0]  hdr_cplsta;
  logic [11:0] hdr_bytecount;
  logic [6:0]  hdr_loaddr;

  logic [63:0] pld_tdata;
  logic [7:0]  pld_tkeep;
  logic        pld_tlast;
  logic        pld_tvalid;
  logic        pld_tready;

  modport master (
    output rx_tdata, rx_tkeep, rx_tlast, rx_tvalid, rx_tuser, hdr_ready, pld_tready,
    input  rx_tready, hdr_valid, hdr_fmt, hdr_type, hdr_len, hdr_reqid, hdr_tag,
           hdr_firstbe, hdr_lastbe, hdr_addr, hdr_bar, hdr_cplid, hdr_cplsta,
           hdr_bytecount, hdr_loaddr, pld_tdata, pld_tkeep, pld_tlast, pld_tvalid
  );

  modport slave (
    input  rx_tdata, rx_tkeep, rx_tlast, rx_tvalid, rx_tuser, hdr_ready, pld_tready,
    output rx_tready, hdr_valid, hdr_fmt, hdr_type, hdr_len, hdr_reqid, hdr_tag,
           hdr_firstbe, hdr_lastbe, hdr_addr, hdr_bar, hdr_cplid, hdr_cplsta,
           hdr_bytecount, hdr_loaddr, pld_tdata, pld_tkeep, pld_tlast, pld_tvalid
  );
endinterface

// File: rtl/pcie_rx_tlp_parser.sv
// PCIe RX TLP parser: decodes memory request / completion headers from the 64-bit core
// stream into a one-entry header register and re-emits the payload dword-0 aligned.
module pcie_rx_tlp_parser #(
  parameter logic [7:0]  BAR_EN = 8'h01,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                pcie_clk,
  input  logic                pcie_rst,
  pcie_rx_tlp_parser_if.slave bus,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [CNT_W-1:0]    err_cnt
);
  localparam logic [4:0] TYPE_MEMRW = 5'b00000;
  localparam logic [4:0] TYPE_COMPL = 5'b01010;

  typedef enum logic [2:0] {H0, H1, DATA, FLUSH, DROP} state_t;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [10:0] len;
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic [3:0]  firstbe;
    logic [3:0]  lastbe;
    logic [61:0] addr;
    logic [7:0]  bar;
    logic [15:0] cplid;
    logic [2:0]  cplsta;
    logic [11:0] bytecount;
    logic [6:0]  loaddr;
  } hdr_t;

  state_t           state_q, state_d;
  hdr_t             hdr_q, hdr_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [31:0]      hold_q, hold_d;
  logic [10:0]      rem_q, rem_d;
  logic             drop_after_q, drop_after_d;
  logic [63:0]      pld_data_q, pld_data_d;
  logic [7:0]       pld_keep_q, pld_keep_d;
  logic             pld_last_q, pld_last_d;
  logic             pld_valid_q, pld_valid_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

  logic        rx_ready, beat, last_in, pld_free, supported, drop_inc, err_inc;
  logic [31:0] dw_lo, dw_hi;
  logic        unused_bits;

  // Bar hit vector lives in rx_tuser[9:2]; only rx_tkeep[4] distinguishes a half beat.
  assign dw_lo       = bus.rx_tdata[31:0];
  assign dw_hi       = bus.rx_tdata[63:32];
  assign last_in     = bus.rx_tlast;
  assign beat        = bus.rx_tvalid && rx_ready;
  assign pld_free    = !pld_valid_q || bus.pld_tready;
  assign supported   = (hdr_q.typ == TYPE_MEMRW && (hdr_q.bar & BAR_EN) != 8'h00) ||
                       (hdr_q.typ == TYPE_COMPL && !hdr_q.fmt[0]);
  assign unused_bits = ^{bus.rx_tkeep[7:5], bus.rx_tkeep[3:0],
                         bus.rx_tuser[21:10], bus.rx_tuser[1:0]};

  always_comb begin
    case (state_q)
      H0:       rx_ready = !(hdr_valid_q && !bus.hdr_ready);
      H1, DATA: rx_ready = pld_free;
      FLUSH:    rx_ready = 1'b0;
      default:  rx_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    hdr_valid_d  = hdr_valid_q && !bus.hdr_ready;
    hold_d       = hold_q;
    rem_d        = rem_q;
    drop_after_d = drop_after_q;
    pld_data_d   = pld_data_q;
    pld_keep_d   = pld_keep_q;
    pld_last_d   = pld_last_q;
    pld_valid_d  = pld_valid_q && !bus.pld_tready;
    drop_inc     = 1'b0;
    err_inc      = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      H0: if (beat) begin
        hdr_d     = '0;
        hdr_d.fmt = dw_lo[30:29];
        hdr_d.typ = dw_lo[28:24];
        hdr_d.len = {(dw_lo[9:0] == 10'd0), dw_lo[9:0]};
        hdr_d.bar = bus.rx_tuser[9:2];
        if (dw_lo[28:24] == TYPE_COMPL) begin
          hdr_d.cplid     = dw_hi[31:16];
          hdr_d.cplsta    = dw_hi[15:13];
          hdr_d.bytecount = dw_hi[11:0];
        end else begin
          hdr_d.reqid   = dw_hi[31:16];
          hdr_d.tag     = dw_hi[15:8];
          hdr_d.lastbe  = dw_hi[7:4];
          hdr_d.firstbe = dw_hi[3:0];
        end
        if (last_in) drop_inc = 1'b1;
        else         state_d  = H1;
      end

      H1: if (beat) begin
        if (hdr_q.typ == TYPE_COMPL) begin
          hdr_d.reqid  = dw_lo[31:16];
          hdr_d.tag    = dw_lo[15:8];
          hdr_d.loaddr = dw_lo[6:0];
        end else if (hdr_q.fmt[0]) begin
          hdr_d.addr = {dw_lo, dw_hi[31:2]};
        end else begin
          hdr_d.addr = {32'h0, dw_lo[31:2]};
        end
        hold_d = dw_hi;
        if (!supported) begin
          drop_inc = 1'b1;
          state_d  = last_in ? H0 : DROP;
        end else begin
          hdr_valid_d = 1'b1;
          if (!hdr_q.fmt[1]) begin
            err_inc = !last_in;
            state_d = last_in ? H0 : DROP;
          end else if (hdr_q.fmt[0]) begin
            rem_d   = hdr_q.len;
            err_inc = last_in;
            state_d = last_in ? H0 : DATA;
          end else if (last_in || hdr_q.len == 11'd1) begin
            // Single payload dword sits in the upper half of beat 1.
            pld_data_d  = {32'h0, dw_hi};
            pld_keep_d  = 8'h0F;
            pld_last_d  = 1'b1;
            pld_valid_d = 1'b1;
            err_inc     = !(last_in && hdr_q.len == 11'd1);
            state_d     = last_in ? H0 : DROP;
          end else begin
            rem_d   = hdr_q.len;
            state_d = DATA;
          end
        end
      end

      DATA: if (beat) begin
        pld_valid_d = 1'b1;
        if (hdr_q.fmt[0]) begin
          pld_data_d = bus.rx_tdata;
          if (rem_q <= 11'd2) begin
            pld_keep_d = (rem_q == 11'd1) ? 8'h0F : 8'hFF;
            pld_last_d = 1'b1;
            err_inc    = !last_in;
            state_d    = last_in ? H0 : DROP;
          end else begin
            pld_keep_d = bus.rx_tkeep[4] ? 8'hFF : 8'h0F;
            pld_last_d = last_in;
            rem_d      = rem_q - 11'd2;
            err_inc    = last_in;
            if (last_in) state_d = H0;
          end
        end else begin
          // rem_q counts the held dword plus everything still to arrive.
          pld_data_d = {dw_lo, hold_q};
          pld_keep_d = 8'hFF;
          pld_last_d = 1'b0;
          hold_d     = dw_hi;
          rem_d      = rem_q - 11'd2;
          if (rem_q <= 11'd2) begin
            pld_last_d = 1'b1;
            err_inc    = !last_in;
            state_d    = last_in ? H0 : DROP;
          end else if (last_in && !bus.rx_tkeep[4]) begin
            pld_last_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = H0;
          end else if (last_in) begin
            drop_after_d = 1'b0;
            err_inc      = (rem_q != 11'd3);
            state_d      = FLUSH;
          end else if (rem_q == 11'd3) begin
            drop_after_d = 1'b1;
            err_inc      = 1'b1;
            state_d      = FLUSH;
          end
        end
      end

      FLUSH: if (pld_free) begin
        pld_data_d  = {32'h0, hold_q};
        pld_keep_d  = 8'h0F;
        pld_last_d  = 1'b1;
        pld_valid_d = 1'b1;
        state_d     = drop_after_q ? DROP : H0;
      end

      default: if (beat && last_in) state_d = H0;
    endcase

    if (drop_inc && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (err_inc && !(&err_cnt_q))   err_cnt_d  = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q      <= H0;
      hdr_q        <= '0;
      hdr_valid_q  <= 1'b0;
      hold_q       <= 32'h0;
      rem_q        <= 11'd0;
      drop_after_q <= 1'b0;
      pld_data_q   <= 64'h0;
      pld_keep_q   <= 8'h00;
      pld_last_q   <= 1'b0;
      pld_valid_q  <= 1'b0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      hdr_valid_q  <= hdr_valid_d;
      hold_q       <= hold_d;
      rem_q        <= rem_d;
      drop_after_q <= drop_after_d;
      pld_data_q   <= pld_data_d;
      pld_keep_q   <= pld_keep_d;
      pld_last_q   <= pld_last_d;
      pld_valid_q  <= pld_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.rx_tready     = rx_ready;
  assign bus.hdr_valid     = hdr_valid_q;
  assign bus.hdr_fmt       = hdr_q.fmt;
  assign bus.hdr_type      = hdr_q.typ;
  assign bus.hdr_len       = hdr_q.len;
  assign bus.hdr_reqid     = hdr_q.reqid;
  assign bus.hdr_tag       = hdr_q.tag;
  assign bus.hdr_firstbe   = hdr_q.firstbe;
  assign bus.hdr_lastbe    = hdr_q.lastbe;
  assign bus.hdr_addr      = hdr_q.addr;
  assign bus.hdr_bar       = hdr_q.bar;
  assign bus.hdr_cplid     = hdr_q.cplid;
  assign bus.hdr_cplsta    = hdr_q.cplsta;
  assign bus.hdr_bytecount = hdr_q.bytecount;
  assign bus.hdr_loaddr    = hdr_q.loaddr;
  assign bus.pld_tdata     = pld_data_q;
  assign bus.pld_tkeep     = pld_keep_q;
  assign bus.pld_tlast     = pld_last_q;
  assign bus.pld_tvalid    = pld_valid_q;
  assign drop_cnt          = drop_cnt_q;
  assign err_cnt           = err_cnt_q;
endmodule
